// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area geometry, the palette-index type and
// the sprite update sequencer state encoding.
package vga_pkg;

  localparam int VGA_DISPLAY_WIDTH  = 640;
  localparam int VGA_DISPLAY_HEIGHT = 480;

  typedef logic [2:0] palette_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/vga_sprite_bounce_engine_if.sv
// Pixel bus between the sync generator side and the sprite engine.
//   pix_x, pix_y, video_active : current pixel from the sync generator
//   hit, hit_id, local_x,
//   local_y, hit_color         : registered hit-test result for that pixel
// master = pixel source / result consumer, slave = sprite engine.
interface vga_sprite_bounce_engine_if
  import vga_pkg::*;
#(
  parameter int ID_W  = 3,
  parameter int LOC_W = 6
);
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic             video_active;
  logic             hit;
  logic [ID_W-1:0]  hit_id;
  logic [LOC_W-1:0] local_x;
  logic [LOC_W-1:0] local_y;
  palette_idx_t     hit_color;

  modport master (
    output pix_x, pix_y, video_active,
    input  hit, hit_id, local_x, local_y, hit_color
  );

  modport slave (
    input  pix_x, pix_y, video_active,
    output hit, hit_id, local_x, local_y, hit_color
  );
endinterface

// File: rtl/vga_sprite_bounce_engine_axis_step.sv
// sprite_axis_step: combinational single-axis move for one sprite.
//   pos, dir, step, max_pos : current position, direction (1 = increasing),
//                             step size and upper clamp
//   pos_next, dir_next      : next position and direction
//   bounce                  : the axis reversed this update
// Arithmetic is one bit wider than the position so pos+step cannot wrap.
module sprite_axis_step #(
  parameter int SPEED_W = 3
) (
  input  logic [9:0]         pos,
  input  logic               dir,
  input  logic [SPEED_W-1:0] step,
  input  logic [9:0]         max_pos,
  output logic [9:0]         pos_next,
  output logic               dir_next,
  output logic               bounce
);
  logic [10:0] pos_w;
  logic [10:0] step_w;
  logic [10:0] sum;

  always_comb begin
    pos_w    = {1'b0, pos};
    step_w   = 11'(step);
    sum      = pos_w + step_w;
    pos_next = pos;
    dir_next = dir;
    bounce   = 1'b0;
    // A zero step freezes the axis, including a sprite parked at the clamp.
    if (step != '0) begin
      if (dir) begin
        if (sum >= {1'b0, max_pos}) begin
          pos_next = max_pos;
          dir_next = 1'b0;
          bounce   = 1'b1;
        end else begin
          pos_next = sum[9:0];
        end
      end else if (pos_w < step_w) begin
        pos_next = '0;
        dir_next = 1'b1;
        bounce   = 1'b1;
      end else begin
        // pos == step lands on 0 without reversing; reversal comes next frame.
        pos_next = 10'(pos_w - step_w);
      end
    end
  end
endmodule

// File: rtl/vga_sprite_bounce_engine.sv
// vga_sprite_bounce_engine: N bouncing sprites with a per-pixel hit test.
//   clk, rst_n  : clock, synchronous active-low reset
//   frame_tick  : one-cycle pulse at the start of a frame
//   pause       : ignore frame_tick while high
//   speed       : pixels per frame per axis, latched at frame start
//   pix         : pixel bus (slave) - pixel in, registered hit result out
//   bounce      : one-cycle pulse per sprite that reversed on any axis
//   busy        : update sequencer active (N_SPRITES+1 cycles per frame)
module vga_sprite_bounce_engine
  import vga_pkg::*;
#(
  parameter int N_SPRITES      = 4,
  parameter int SPRITE_SIZE    = 64,
  parameter int DISPLAY_WIDTH  = VGA_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = VGA_DISPLAY_HEIGHT,
  parameter int SPEED_W        = 3,
  parameter int ID_W           = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  vga_sprite_bounce_engine_if.slave pix,
  output logic               bounce,
  output logic               busy
);
  localparam int              LOC_W    = $clog2(SPRITE_SIZE);
  localparam logic [9:0]      MAX_X    = 10'(DISPLAY_WIDTH - SPRITE_SIZE);
  localparam logic [9:0]      MAX_Y    = 10'(DISPLAY_HEIGHT - SPRITE_SIZE);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SPRITES - 1);

  if ((N_SPRITES - 1) * (SPRITE_SIZE / 2) > DISPLAY_WIDTH - SPRITE_SIZE) begin : g_bad_layout
    $error("reset layout places sprites outside the visible width");
  end
  if ((SPRITE_SIZE & (SPRITE_SIZE - 1)) != 0) begin : g_bad_size
    $error("SPRITE_SIZE must be a power of two");
  end
  if ((1 << ID_W) < N_SPRITES) begin : g_bad_id_w
    $error("ID_W too narrow for N_SPRITES");
  end

  logic [9:0]   sp_left  [N_SPRITES];
  logic [9:0]   sp_top   [N_SPRITES];
  logic         sp_dir_x [N_SPRITES];
  logic         sp_dir_y [N_SPRITES];
  palette_idx_t sp_color [N_SPRITES];

  seq_state_t         state;
  logic [ID_W-1:0]    idx;
  logic [SPEED_W-1:0] step;

  logic [9:0] x_next, y_next;
  logic       x_dir_next, y_dir_next, x_bounce, y_bounce;

  // One shared X/Y step pair serves whichever sprite idx selects.
  sprite_axis_step #(.SPEED_W(SPEED_W)) u_step_x (
    .pos(sp_left[idx]), .dir(sp_dir_x[idx]), .step(step), .max_pos(MAX_X),
    .pos_next(x_next), .dir_next(x_dir_next), .bounce(x_bounce)
  );

  sprite_axis_step #(.SPEED_W(SPEED_W)) u_step_y (
    .pos(sp_top[idx]), .dir(sp_dir_y[idx]), .step(step), .max_pos(MAX_Y),
    .pos_next(y_next), .dir_next(y_dir_next), .bounce(y_bounce)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      step   <= '0;
      busy   <= 1'b0;
      bounce <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        sp_left[i]  <= 10'(i * (SPRITE_SIZE / 2));
        sp_top[i]   <= 10'(i * (SPRITE_SIZE / 4));
        sp_dir_x[i] <= (i % 2) == 0;
        sp_dir_y[i] <= (i % 2) == 1;
        sp_color[i] <= palette_idx_t'(i % 8);
      end
    end else begin
      bounce <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_tick && !pause) begin
            state <= ST_UPDATE;
            step  <= speed;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_UPDATE: begin
          sp_left[idx]  <= x_next;
          sp_top[idx]   <= y_next;
          sp_dir_x[idx] <= x_dir_next;
          sp_dir_y[idx] <= y_dir_next;
          // A corner hit reverses both axes but advances the colour once.
          if (x_bounce || y_bounce) begin
            sp_color[idx] <= sp_color[idx] + 3'd1;
          end
          bounce <= x_bounce || y_bounce;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + ID_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic             cover_any;
  logic [ID_W-1:0]  win_id;
  logic [LOC_W-1:0] win_lx, win_ly;
  palette_idx_t     win_col;
  logic [9:0]       dx, dy;

  // Scan from the highest index down so the lowest covering index wins.
  always_comb begin
    cover_any = 1'b0;
    win_id    = '0;
    win_lx    = '0;
    win_ly    = '0;
    win_col   = '0;
    dx        = '0;
    dy        = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      dx = pix.pix_x - sp_left[i];
      dy = pix.pix_y - sp_top[i];
      if (pix.video_active && dx[9:LOC_W] == '0 && dy[9:LOC_W] == '0) begin
        cover_any = 1'b1;
        win_id    = ID_W'(i);
        win_lx    = dx[LOC_W-1:0];
        win_ly    = dy[LOC_W-1:0];
        win_col   = sp_color[i];
      end
    end
  end

  // ---- hit stage: one cycle after pix_x/pix_y ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix.hit       <= 1'b0;
      pix.hit_id    <= '0;
      pix.local_x   <= '0;
      pix.local_y   <= '0;
      pix.hit_color <= '0;
    end else begin
      pix.hit       <= cover_any;
      pix.hit_id    <= win_id;
      pix.local_x   <= win_lx;
      pix.local_y   <= win_ly;
      pix.hit_color <= win_col;
    end
  end
endmodule
